// File: rtl/mat_add_ctrl_if.sv
// Command/result handshake bundle between the command decoder and mat_add_ctrl.
// The controller is the slave: it accepts commands and offers results.
interface mat_add_ctrl_if;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [63:0]  cmd_mat_A;
   logic [63:0]  cmd_mat_B;
   logic         res_valid;
   logic         res_ready;
   logic [159:0] res_data;
   logic         res_err;

   modport master (
      output cmd_valid, cmd_op, cmd_mat_A, cmd_mat_B, res_ready,
      input  cmd_ready, res_valid, res_data, res_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_mat_A, cmd_mat_B, res_ready,
      output cmd_ready, res_valid, res_data, res_err
   );
endinterface

// File: rtl/mat_add_ctrl.sv
// Command-level sequencer for the 4x4 add/subtract datapath.
// Accepts one ADD/SUB command, clears and starts the datapath, waits for its
// finish flag (with a timeout), and hands the 160-bit result back.
module mat_add_ctrl #(
   parameter int TIMEOUT = 16   // WAIT cycles without finish before abort, 10..255
) (
   input  logic           clk,
   input  logic           rst,
   mat_add_ctrl_if.slave  bus,
   output logic [63:0]    path_mat_A,
   output logic [63:0]    path_mat_B,
   output logic           path_add_en,
   output logic           path_sign,
   output logic           path_rst,
   input  logic [159:0]   path_mat_out,
   input  logic           path_finish,
   output logic [7:0]     op_count
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CLR  = 3'd1,
      RUN  = 3'd2,
      WAIT = 3'd3,
      DONE = 3'd4
   } state_t;

   // Last counter value of the WAIT window; the op aborts when it is reached.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t         state_reg,  state_next;
   logic [63:0]    mat_a_reg,  mat_a_next;
   logic [63:0]    mat_b_reg,  mat_b_next;
   logic           sign_reg,   sign_next;
   logic [159:0]   data_reg,   data_next;
   logic           err_reg,    err_next;
   logic [7:0]     tmo_reg,    tmo_next;
   logic [7:0]     count_reg,  count_next;

   logic           op_legal;

   // Only ADD (00) and SUB (01) are legal; the sign bit is cmd_op[0].
   assign op_legal = (bus.cmd_op[1] == 1'b0);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Datapath-facing operand latches, result capture, timeout and op counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         mat_a_reg <= '0;
         mat_b_reg <= '0;
         sign_reg  <= 1'b0;
         data_reg  <= '0;
         err_reg   <= 1'b0;
         tmo_reg   <= '0;
         count_reg <= '0;
      end else begin
         mat_a_reg <= mat_a_next;
         mat_b_reg <= mat_b_next;
         sign_reg  <= sign_next;
         data_reg  <= data_next;
         err_reg   <= err_next;
         tmo_reg   <= tmo_next;
         count_reg <= count_next;
      end
   end

   // Next-state and register-update logic; every value holds unless changed.
   always_comb begin
      state_next = state_reg;
      mat_a_next = mat_a_reg;
      mat_b_next = mat_b_reg;
      sign_next  = sign_reg;
      data_next  = data_reg;
      err_next   = err_reg;
      tmo_next   = tmo_reg;
      count_next = count_reg;

      unique case (state_reg)
         IDLE: begin
            if (bus.cmd_valid) begin
               mat_a_next = bus.cmd_mat_A;
               mat_b_next = bus.cmd_mat_B;
               if (op_legal) begin
                  sign_next  = bus.cmd_op[0];
                  state_next = CLR;
               end else begin
                  // Illegal opcode: report an error without touching the datapath.
                  data_next  = '0;
                  err_next   = 1'b1;
                  state_next = DONE;
               end
            end
         end
         CLR: begin
            // A finish flag left over from the previous op is ignored here.
            state_next = RUN;
         end
         RUN: begin
            tmo_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            tmo_next = tmo_reg + 8'd1;
            if (path_finish) begin
               // Finish has priority over a timeout in the same cycle.
               data_next  = path_mat_out;
               err_next   = 1'b0;
               count_next = count_reg + 8'd1;
               state_next = DONE;
            end else if (tmo_reg == TMO_LAST) begin
               data_next  = '0;
               err_next   = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (bus.res_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs decoded from the registered state; path_rst also follows rst directly.
   assign bus.cmd_ready = (state_reg == IDLE) && !rst;
   assign bus.res_valid = (state_reg == DONE);
   assign bus.res_data  = data_reg;
   assign bus.res_err   = err_reg;
   assign path_mat_A    = mat_a_reg;
   assign path_mat_B    = mat_b_reg;
   assign path_sign     = sign_reg;
   assign path_add_en   = (state_reg == RUN);
   assign path_rst      = rst || (state_reg == CLR);
   assign op_count      = count_reg;

endmodule

// File: tb/tb_mat_add_ctrl.sv
// Directed testbench for mat_add_ctrl with a behavioural stub of the add datapath.
module tb_mat_add_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mat_add_ctrl_if bus ();

   logic [63:0]  path_mat_A;
   logic [63:0]  path_mat_B;
   logic         path_add_en;
   logic         path_sign;
   logic         path_rst;
   logic [159:0] path_mat_out;
   logic         path_finish;
   logic [7:0]   op_count;

   mat_add_ctrl #(.TIMEOUT(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .path_mat_A   (path_mat_A),
      .path_mat_B   (path_mat_B),
      .path_add_en  (path_add_en),
      .path_sign    (path_sign),
      .path_rst     (path_rst),
      .path_mat_out (path_mat_out),
      .path_finish  (path_finish),
      .op_count     (op_count)
   );

   // Datapath stub: eight compute cycles after the start pulse, then a level
   // finish flag that stays up until the next path_rst. stub_hang suppresses it.
   logic         stub_hang = 1'b0;
   logic         stub_run;
   int           stub_cnt;
   logic [159:0] stub_result;

   always_comb begin
      stub_result = '0;
      for (int i = 0; i < 16; i++) begin
         logic [9:0] ea, eb;
         ea = {6'd0, path_mat_A[63-4*i -: 4]};
         eb = {6'd0, path_mat_B[63-4*i -: 4]};
         stub_result[159-10*i -: 10] = path_sign ? (ea - eb) : (ea + eb);
      end
   end

   always @(posedge clk) begin
      if (path_rst) begin
         stub_run     <= 1'b0;
         stub_cnt     <= 0;
         path_finish  <= 1'b0;
         path_mat_out <= '0;
      end else if (path_add_en) begin
         stub_run <= 1'b1;
         stub_cnt <= 1;
      end else if (stub_run && stub_cnt < 8) begin
         stub_cnt <= stub_cnt + 1;
      end else if (stub_run && !stub_hang) begin
         path_finish  <= 1'b1;
         path_mat_out <= stub_result;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Offer a command and return #1 after the accepting edge (cycle 1).
   task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      int guard;
      bus.cmd_op    = op;
      bus.cmd_mat_A = a;
      bus.cmd_mat_B = b;
      bus.cmd_valid = 1'b1;
      guard = 0;
      while (!bus.cmd_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("cmd_ready_before_accept", {159'd0, bus.cmd_ready}, 160'd1);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   // Wait for res_valid starting at cycle 1; counts cycles and datapath activity.
   task automatic wait_res(input logic [1:0] op, output int lat, output logic [159:0] data,
                           output logic err, output int en_cnt, output int prst_cnt,
                           output logic sign_ok);
      lat = 1; en_cnt = 0; prst_cnt = 0; sign_ok = 1'b1;
      while (!bus.res_valid && lat < 100) begin
         en_cnt   += int'(path_add_en);
         prst_cnt += int'(path_rst);
         if (op[1] == 1'b0 && path_sign !== op[0]) sign_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      check("res_valid_seen", {159'd0, bus.res_valid}, 160'd1);
      data = bus.res_data;
      err  = bus.res_err;
      $display("op=%b lat=%0d err=%b en=%0d prst=%0d count=%0d data=%h",
               op, lat, err, en_cnt, prst_cnt, op_count, data);
   endtask

   task automatic release_res();
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
   endtask

   logic [159:0] f008, f005, f01e;
   int           lat, en_cnt, prst_cnt;
   logic [159:0] data;
   logic         err, sign_ok, stable, rdy_seen;

   initial begin
      f008 = {16{10'h008}};
      f005 = {16{10'h005}};
      f01e = {16{10'h01E}};
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_mat_A = '0;
      bus.cmd_mat_B = '0;
      bus.res_ready = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", {159'd0, bus.cmd_ready}, 160'd0);
      check("rst_path_rst",  {159'd0, path_rst},      160'd1);
      check("rst_res_valid", {159'd0, bus.res_valid}, 160'd0);
      check("rst_add_en",    {159'd0, path_add_en},   160'd0);
      check("rst_res_data",  bus.res_data,            160'd0);
      check("rst_op_count",  {152'd0, op_count},      160'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_cmd_ready", {159'd0, bus.cmd_ready}, 160'd1);
      check("idle_path_rst",  {159'd0, path_rst},      160'd0);

      // ADD 3+5 with res_ready held high.
      bus.res_ready = 1'b1;
      issue(2'b00, {16{4'h3}}, {16{4'h5}});
      wait_res(2'b00, lat, data, err, en_cnt, prst_cnt, sign_ok);
      check("add1_lat",   lat,  12);
      check("add1_data",  data, f008);
      check("add1_err",   {159'd0, err}, 160'd0);
      check("add1_count", {152'd0, op_count}, 160'd1);
      check("add1_en",    en_cnt, 1);
      @(posedge clk); #1;
      bus.res_ready = 1'b0;

      // SUB 9-4.
      issue(2'b01, {16{4'h9}}, {16{4'h4}});
      wait_res(2'b01, lat, data, err, en_cnt, prst_cnt, sign_ok);
      check("sub_lat",   lat,  12);
      check("sub_data",  data, f005);
      check("sub_sign",  {159'd0, sign_ok}, 160'd1);
      check("sub_count", {152'd0, op_count}, 160'd2);
      release_res();

      // ADD F+F; its CLR cycle pulses path_rst once.
      issue(2'b00, {16{4'hF}}, {16{4'hF}});
      wait_res(2'b00, lat, data, err, en_cnt, prst_cnt, sign_ok);
      check("addf_data",  data, f01e);
      check("addf_prst",  prst_cnt, 1);
      check("addf_count", {152'd0, op_count}, 160'd3);
      release_res();

      // Illegal opcodes: one-cycle latency, error, no datapath activity.
      issue(2'b10, {16{4'h1}}, {16{4'h2}});
      wait_res(2'b10, lat, data, err, en_cnt, prst_cnt, sign_ok);
      check("ill10_lat",   lat, 1);
      check("ill10_err",   {159'd0, err}, 160'd1);
      check("ill10_data",  data, 160'd0);
      check("ill10_en",    en_cnt + int'(path_add_en), 0);
      check("ill10_count", {152'd0, op_count}, 160'd3);
      release_res();
      issue(2'b11, {16{4'h1}}, {16{4'h2}});
      wait_res(2'b11, lat, data, err, en_cnt, prst_cnt, sign_ok);
      check("ill11_err",  {159'd0, err}, 160'd1);
      check("ill11_sign", {159'd0, path_sign}, 160'd0);
      release_res();

      // Hung datapath: 16 WAIT cycles after RUN, then error.
      stub_hang = 1'b1;
      issue(2'b00, {16{4'h3}}, {16{4'h5}});
      wait_res(2'b00, lat, data, err, en_cnt, prst_cnt, sign_ok);
      check("tmo_lat",   lat, 19);
      check("tmo_err",   {159'd0, err}, 160'd1);
      check("tmo_data",  data, 160'd0);
      check("tmo_count", {152'd0, op_count}, 160'd3);
      release_res();
      check("tmo_idle", {159'd0, bus.cmd_ready}, 160'd1);
      stub_hang = 1'b0;

      // Result held in DONE for 20 cycles while a new command is offered.
      issue(2'b00, {16{4'h3}}, {16{4'h5}});
      wait_res(2'b00, lat, data, err, en_cnt, prst_cnt, sign_ok);
      check("hold_data", data, f008);
      bus.cmd_op    = 2'b01;
      bus.cmd_mat_A = {16{4'h9}};
      bus.cmd_mat_B = {16{4'h4}};
      bus.cmd_valid = 1'b1;
      stable = 1'b1; rdy_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.res_data !== f008 || !bus.res_valid) stable = 1'b0;
         if (bus.cmd_ready) rdy_seen = 1'b1;
      end
      check("hold_stable",  {159'd0, stable},   160'd1);
      check("hold_noready", {159'd0, rdy_seen}, 160'd0);
      check("hold_count",   {152'd0, op_count}, 160'd4);
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      check("rel_res_valid", {159'd0, bus.res_valid}, 160'd0);
      check("rel_cmd_ready", {159'd0, bus.cmd_ready}, 160'd1);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      check("rel_accepted", {159'd0, bus.cmd_ready}, 160'd0);
      check("rel_sign",     {159'd0, path_sign},     160'd1);
      wait_res(2'b01, lat, data, err, en_cnt, prst_cnt, sign_ok);
      check("rel_lat",   lat, 12);
      check("rel_data",  data, f005);
      check("rel_count", {152'd0, op_count}, 160'd5);
      release_res();

      // Reset during the fifth WAIT cycle, then a fresh op.
      issue(2'b00, {16{4'h3}}, {16{4'h5}});
      repeat (6) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check("mid_path_rst", {159'd0, path_rst}, 160'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("mid_res_valid", {159'd0, bus.res_valid}, 160'd0);
      check("mid_op_count",  {152'd0, op_count},      160'd0);
      check("mid_cmd_ready", {159'd0, bus.cmd_ready}, 160'd1);
      check("mid_mat_A",     {96'd0, path_mat_A},     160'd0);
      issue(2'b00, {16{4'hF}}, {16{4'hF}});
      wait_res(2'b00, lat, data, err, en_cnt, prst_cnt, sign_ok);
      check("post_lat",   lat, 12);
      check("post_data",  data, f01e);
      check("post_count", {152'd0, op_count}, 160'd1);
      release_res();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
